led_sequence_controller: RTL

//   Sequences a small LED-pattern memory onto the board LEDs at a divided step rate.

---
 rtl/led_seq_pkg.sv | 9 +
 rtl/tick_prescaler.sv | 22 ++
 rtl/led_sequence_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared mode codes, FSM state and ping-pong direction encodings
// for the LED sequencer.
package led_seq_pkg;
    localparam logic [1:0] MODE_ONCE     = 2'd0;
    localparam logic [1:0] MODE_LOOP     = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running 2**DIV_BITS divider while enabled; TICK pulses
// for one cycle when the count is all-ones.
module tick_prescaler #(
    parameter int DIV_BITS = 21
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);
    logic [DIV_BITS-1:0] cnt;
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            cnt <= '0;
        else if (CLR)
            cnt <= '0;
        else if (EN)
            cnt <= cnt + 1'b1;
    end
    assign TICK = EN && (&cnt);
endmodule

// File: rtl/led_sequence_controller.sv
// led_sequence_controller: plays a small LED-pattern RAM onto the LED bus at a
// divided step rate in once, loop or ping-pong mode under START/STOP control.
module led_sequence_controller
    import led_seq_pkg::*;
#(
    parameter int NLEDS    = 5,
    parameter int AW       = 4,
    parameter int DIV_BITS = 21
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic             STOP,
    input  logic [1:0]       MODE,
    input  logic [AW-1:0]    LAST,
    input  logic             WE,
    input  logic [AW-1:0]    WADDR,
    input  logic [NLEDS-1:0] WDATA,
    output logic [NLEDS-1:0] LED,
    output logic [AW-1:0]    PC,
    output logic             BUSY,
    output logic             DONE
);
    localparam int DEPTH = 2**AW;
    logic [NLEDS-1:0] ram [DEPTH];
    state_t state, state_n;
    dir_t dir, dir_n;
    logic [AW-1:0] pc, pc_n, last, last_n;
    logic [NLEDS-1:0] led, led_n;
    logic [1:0] mode, mode_n;
    logic done, done_n, tick;

    tick_prescaler #(.DIV_BITS(DIV_BITS)) u_prescaler (
        .CLK(CLK),
        .RESETN(RESETN),
        .EN(state == ST_RUN),
        .CLR(state == ST_IDLE),
        .TICK(tick)
    );

    // Unregistered-reset RAM; the tick read samples the pre-write word.
    always_ff @(posedge CLK) begin
        if (WE)
            ram[WADDR] <= WDATA;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= ST_IDLE;
            dir   <= DIR_UP;
            pc    <= '0;
            led   <= '0;
            done  <= 1'b0;
            mode  <= MODE_ONCE;
            last  <= '0;
        end else begin
            state <= state_n;
            dir   <= dir_n;
            pc    <= pc_n;
            led   <= led_n;
            done  <= done_n;
            mode  <= mode_n;
            last  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir;
        pc_n    = pc;
        led_n   = led;
        done_n  = 1'b0;
        mode_n  = mode;
        last_n  = last;
        if (state == ST_IDLE) begin
            if (START && !STOP) begin
                state_n = ST_RUN;
                pc_n    = '0;
                dir_n   = DIR_UP;
                mode_n  = (MODE == MODE_ONCE || MODE == MODE_PINGPONG) ? MODE : MODE_LOOP;
                last_n  = LAST;
            end
        end else begin
            if (tick)
                led_n = ram[pc];
            if (STOP) begin
                state_n = ST_IDLE;
                pc_n    = '0;
            end else if (tick) begin
                if (mode == MODE_ONCE) begin
                    if (pc == last) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                        pc_n    = '0;
                    end else begin
                        pc_n = pc + 1'b1;
                    end
                end else if (mode == MODE_LOOP) begin
                    pc_n = (pc == last) ? '0 : pc + 1'b1;
                end else if (last == '0) begin
                    pc_n = '0;
                end else if (dir == DIR_UP && pc == last) begin
                    dir_n = DIR_DOWN;
                    pc_n  = pc - 1'b1;
                end else if (dir == DIR_DOWN && pc == '0) begin
                    dir_n = DIR_UP;
                    pc_n  = pc + 1'b1;
                end else begin
                    pc_n = (dir == DIR_UP) ? pc + 1'b1 : pc - 1'b1;
                end
            end
        end
    end

    assign LED  = led;
    assign PC   = pc;
    assign BUSY = (state == ST_RUN);
    assign DONE = done;
endmodule
